// File: rtl/arinc_pkg.sv
// arinc_pkg: shared definitions for the ARINC line packer (fifo2arinc).
// Holds the transmit FSM state type, word/pixel geometry, the default sync
// words, the frame word indices used by the receiver, and a helper that
// builds the angle word.
package arinc_pkg;

    // Transmit FSM states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_ANGLE,
        ST_PAYLOAD,
        ST_DRAIN
    } arinc_tx_state_t;

    localparam int WORD_W    = 32;
    localparam int PIX_W     = 3;
    localparam int ANGLE_W   = 9;
    localparam int ANGLE_LSB = 19;

    localparam logic [WORD_W-1:0] DEF_SYNC_WORD0 = 32'hA5A5_0000;
    localparam logic [WORD_W-1:0] DEF_SYNC_WORD1 = 32'h0000_5A5A;

    // Word positions inside a frame, matching the receiver's counting.
    localparam int IDX_ANGLE    = 2;
    localparam int IDX_PAYLOAD0 = 3;

    // Angle sits in bits [27:19]; bits [31:28] and [18:0] are zero.
    function automatic logic [WORD_W-1:0] make_angle_word(input logic [ANGLE_W-1:0] angle);
        return {4'b0000, angle, {ANGLE_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/fifo2arinc_pix_packer.sv
// pix_packer: packs 3-bit FIFO pixels LSB-first into 32-bit words.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         high while a frame is in progress; low clears all state
//   fifo_data      pixel returned one cycle after fifo_read
//   fifo_empty     FIFO empty flag
//   fifo_read      FIFO read strobe (combinational from registered state)
//   word_take      consumer takes the word presented on 'word' this cycle
//   word_avail     a full word, or the zero-padded final remainder, is ready
//   word           low 32 bits of the accumulator
//   all_in         every pixel of the line has been requested and returned
module pix_packer
    import arinc_pkg::*;
#(
    parameter int PIXELS_PER_LINE = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [PIX_W-1:0]  fifo_data,
    input  logic              fifo_empty,
    input  logic              word_take,
    output logic              fifo_read,
    output logic              word_avail,
    output logic [WORD_W-1:0] word,
    output logic              all_in
);

    localparam int ACC_W = 64;
    localparam int CNT_W = $clog2(PIXELS_PER_LINE + 1);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIXELS_PER_LINE);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [6:0]       acc_bits_q, acc_bits_d;
    logic [CNT_W-1:0] pix_req_q, pix_req_d;
    logic             rd_pending_q, rd_pending_d;

    logic [ACC_W-1:0] merged;
    logic [6:0]       bits_after_take;
    logic [6:0]       pending_bits;
    logic             have_full;

    assign pending_bits = rd_pending_q ? 7'd3 : 7'd0;
    assign have_full    = acc_bits_q >= 7'd32;
    assign all_in       = (pix_req_q == PIX_TOTAL) && !rd_pending_q;
    assign word_avail   = have_full || (all_in && acc_bits_q != 7'd0);
    assign word         = acc_q[WORD_W-1:0];

    // Counting the in-flight pixel keeps the accumulator from ever holding
    // more than 34 bits, so a full word is always drained before reading on.
    assign fifo_read = enable && (pix_req_q < PIX_TOTAL) && !fifo_empty
                       && ((acc_bits_q + pending_bits) <= 7'd31);

    // Insert the returning pixel at the current fill level, then remove the
    // taken word. A take with fewer than 32 bits is the padded final flush.
    always_comb begin
        merged = acc_q;
        if (rd_pending_q) begin
            merged = acc_q | ({{(ACC_W-PIX_W){1'b0}}, fifo_data} << acc_bits_q);
        end
        acc_d           = merged;
        bits_after_take = acc_bits_q;
        if (word_take) begin
            if (have_full) begin
                acc_d           = merged >> WORD_W;
                bits_after_take = acc_bits_q - 7'd32;
            end else begin
                acc_d           = '0;
                bits_after_take = '0;
            end
        end
        acc_bits_d   = bits_after_take + pending_bits;
        pix_req_d    = pix_req_q + CNT_W'(fifo_read);
        rd_pending_d = fifo_read;
        if (!enable) begin
            acc_d        = '0;
            acc_bits_d   = '0;
            pix_req_d    = '0;
            rd_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            acc_bits_q   <= '0;
            pix_req_q    <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_bits_q   <= acc_bits_d;
            pix_req_q    <= pix_req_d;
            rd_pending_q <= rd_pending_d;
        end
    end

endmodule

// File: rtl/fifo2arinc.sv
// fifo2arinc: builds one ARINC line frame per start request:
// SYNC_WORD0, SYNC_WORD1, angle word, then the packed pixel payload.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle request, honoured only when idle
//   angle_in      line angle captured with an accepted start
//   fifo_data     pixel from the FIFO (valid one cycle after fifo_read)
//   fifo_empty    FIFO empty flag
//   fifo_read     FIFO read strobe
//   arinc_data    frame word towards the transmitter
//   arinc_valid   arinc_data holds a word
//   arinc_ready   transmitter accepts on arinc_valid && arinc_ready
//   busy          frame in progress
module fifo2arinc
    import arinc_pkg::*;
#(
    parameter int                PIXELS_PER_LINE = 512,
    parameter logic [WORD_W-1:0] SYNC_WORD0      = DEF_SYNC_WORD0,
    parameter logic [WORD_W-1:0] SYNC_WORD1      = DEF_SYNC_WORD1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ANGLE_W-1:0] angle_in,
    input  logic [PIX_W-1:0]   fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_read,
    output logic [WORD_W-1:0]  arinc_data,
    output logic               arinc_valid,
    input  logic               arinc_ready,
    output logic               busy
);

    localparam int PAYLOAD_WORDS = (PIX_W * PIXELS_PER_LINE + WORD_W - 1) / WORD_W;
    localparam int WCNT_W        = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [WCNT_W-1:0] WORDS_LAST = WCNT_W'(PAYLOAD_WORDS);

    arinc_tx_state_t    state_q, state_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [WCNT_W-1:0]  words_q, words_d;

    logic              slot_open;
    logic              word_take;
    logic              word_avail;
    logic [WORD_W-1:0] packed_word;
    logic              all_in;

    pix_packer #(
        .PIXELS_PER_LINE (PIXELS_PER_LINE)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state_q != ST_IDLE),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .word_take  (word_take),
        .fifo_read  (fifo_read),
        .word_avail (word_avail),
        .word       (packed_word),
        .all_in     (all_in)
    );

    // The output register can take a new word when empty or when its
    // current word is being accepted this cycle, which avoids bubbles.
    assign slot_open = !out_valid_q || arinc_ready;

    // The state names the word currently held in the output register; a
    // handshake loads the next one. Leaving to IDLE happens on the handshake
    // of the last payload word so busy drops with it.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        angle_d     = angle_q;
        words_d     = words_q;
        word_take   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    angle_d     = angle_in;
                    out_data_d  = SYNC_WORD0;
                    out_valid_d = 1'b1;
                    words_d     = '0;
                    state_d     = ST_SYNC0;
                end
            end
            ST_SYNC0: begin
                if (slot_open) begin
                    out_data_d  = SYNC_WORD1;
                    out_valid_d = 1'b1;
                    state_d     = ST_SYNC1;
                end
            end
            ST_SYNC1: begin
                if (slot_open) begin
                    out_data_d  = make_angle_word(angle_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_ANGLE;
                end
            end
            ST_ANGLE, ST_PAYLOAD, ST_DRAIN: begin
                if (slot_open) begin
                    if (words_q == WORDS_LAST) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (word_avail) begin
                        out_data_d  = packed_word;
                        out_valid_d = 1'b1;
                        word_take   = 1'b1;
                        words_d     = words_q + WCNT_W'(1);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    if (state_q == ST_ANGLE) begin
                        state_d = ST_PAYLOAD;
                    end
                end
                if (state_d == ST_PAYLOAD && state_q == ST_PAYLOAD && all_in) begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            angle_q     <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            angle_q     <= angle_d;
            words_q     <= words_d;
        end
    end

    assign arinc_data  = out_data_q;
    assign arinc_valid = out_valid_q;
    assign busy        = busy_q;

endmodule
